// File: rtl/cell_fetch_if.sv
// cell_fetch_if: read port between cell_fetch and the cell BRAM.
//   rd_en_out   : read strobe, driven by the fetcher (master)
//   rd_addr_out : read address {gen, row, wordcol}, driven by the fetcher
//   rd_data_in  : read data, driven by the BRAM (slave), 2 cycles after the strobe
interface cell_fetch_if #(
  parameter int ADDR_W = 13,
  parameter int WORD_W = 16
);
  logic              rd_en_out;
  logic [ADDR_W-1:0] rd_addr_out;
  logic [WORD_W-1:0] rd_data_in;

  modport master (output rd_en_out, output rd_addr_out, input rd_data_in);
  modport slave  (input rd_en_out, input rd_addr_out, output rd_data_in);
endinterface

// File: rtl/cell_fetch.sv
// cell_fetch: display-side board reader feeding cell_render.
// For each pixel it looks up the liveness bit of the pixel's cell in the cell
// BRAM, issuing a read only when the pixel enters a new board word, and emits
// hcount/vcount/is_alive with a fixed 4-cycle latency.
// Ports:
//   clk_in, rst_in           : pixel clock, async active-high reset
//   hcount_in, vcount_in     : current pixel coordinates
//   gen_sel_in               : displayable generation, latched at (0,0)
//   bram (master)            : BRAM read port (rd_en_out, rd_addr_out, rd_data_in)
//   hcount_out, vcount_out   : coordinates delayed 4 cycles
//   is_alive_out             : liveness of the cell under (hcount_out, vcount_out)
module cell_fetch #(
  parameter int LOG_CELL_SIZE = 2,
  parameter int BOARD_W       = 256,
  parameter int BOARD_H       = 192,
  parameter int WORD_W        = 16,
  parameter int ADDR_W        = 13
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [10:0]  hcount_in,
  input  logic [9:0]   vcount_in,
  input  logic         gen_sel_in,
  cell_fetch_if.master bram,
  output logic [10:0]  hcount_out,
  output logic [9:0]   vcount_out,
  output logic         is_alive_out
);

  localparam int          ROW_W  = $clog2(BOARD_H);
  localparam int          WC_W   = $clog2(BOARD_W / WORD_W);
  localparam int          BIT_W  = $clog2(WORD_W);
  // Delay stages ahead of the output register (output register is the 4th).
  localparam int unsigned STAGES = 3;

  logic [10:0]       col_d;
  logic [9:0]        row_d;
  logic              in_board_d;
  logic              frame_start_d;
  logic              gen_d;
  logic [ADDR_W-1:0] tag_d;
  logic [BIT_W-1:0]  bit_d;
  logic              fetch_d;
  logic [WORD_W-1:0] word_d;
  logic              alive_d;

  logic              gen_q;
  logic              tag_valid_q;
  logic              rd_en_q;
  // rd_addr_q doubles as the cached tag: it only changes when a read issues.
  logic [ADDR_W-1:0] rd_addr_q;
  // rd_en delayed by 1 and 2 cycles; bit 1 marks rd_data_in valid this cycle.
  logic [1:0]        rd_pend_q;
  logic [WORD_W-1:0] word_q;

  logic [10:0]       h_q     [STAGES];
  logic [9:0]        v_q     [STAGES];
  logic              inb_q   [STAGES];
  logic [BIT_W-1:0]  bit_q   [STAGES];

  logic [10:0]       hcount_q;
  logic [9:0]        vcount_q;
  logic              alive_q;

  always_comb begin
    col_d         = hcount_in >> LOG_CELL_SIZE;
    row_d         = vcount_in >> LOG_CELL_SIZE;
    in_board_d    = (col_d < 11'(BOARD_W)) && (row_d < 10'(BOARD_H));
    frame_start_d = (hcount_in == '0) && (vcount_in == '0);
    // The frame-start pixel already uses the newly selected buffer, so the
    // whole frame is drawn from one generation.
    gen_d         = frame_start_d ? gen_sel_in : gen_q;
    tag_d         = {gen_d, row_d[ROW_W-1:0], col_d[BIT_W +: WC_W]};
    bit_d         = col_d[BIT_W-1:0];
    fetch_d       = in_board_d && (!tag_valid_q || (tag_d != rd_addr_q));
    // Data arriving this cycle is used directly; word_q captures it for the
    // remaining pixels of the word.
    word_d        = rd_pend_q[1] ? bram.rd_data_in : word_q;
    alive_d       = inb_q[STAGES-1] & word_d[bit_q[STAGES-1]];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      gen_q       <= 1'b0;
      tag_valid_q <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_pend_q   <= '0;
      word_q      <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        h_q[i]   <= '0;
        v_q[i]   <= '0;
        inb_q[i] <= 1'b0;
        bit_q[i] <= '0;
      end
      hcount_q    <= '0;
      vcount_q    <= '0;
      alive_q     <= 1'b0;
    end else begin
      gen_q     <= gen_d;
      rd_en_q   <= fetch_d;
      if (fetch_d) begin
        rd_addr_q   <= tag_d;
        tag_valid_q <= 1'b1;
      end
      rd_pend_q <= {rd_pend_q[0], rd_en_q};
      word_q    <= word_d;

      h_q[0]   <= hcount_in;
      v_q[0]   <= vcount_in;
      inb_q[0] <= in_board_d;
      bit_q[0] <= bit_d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        h_q[i]   <= h_q[i-1];
        v_q[i]   <= v_q[i-1];
        inb_q[i] <= inb_q[i-1];
        bit_q[i] <= bit_q[i-1];
      end

      hcount_q <= h_q[STAGES-1];
      vcount_q <= v_q[STAGES-1];
      alive_q  <= alive_d;
    end
  end

  assign bram.rd_en_out   = rd_en_q;
  assign bram.rd_addr_out = rd_addr_q;
  assign hcount_out       = hcount_q;
  assign vcount_out       = vcount_q;
  assign is_alive_out     = alive_q;

endmodule

// File: tb/tb_cell_fetch.sv
module tb_cell_fetch;
  localparam int ADDR_W = 13;
  localparam int WORD_W = 16;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] hcount_in = 11'd1100;
  logic [9:0]  vcount_in = 10'd0;
  logic        gen_sel_in = 1'b0;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        is_alive_out;

  cell_fetch_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  cell_fetch #(
    .LOG_CELL_SIZE(2),
    .BOARD_W(256),
    .BOARD_H(192),
    .WORD_W(WORD_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .hcount_in(hcount_in),
    .vcount_in(vcount_in),
    .gen_sel_in(gen_sel_in),
    .bram(bus),
    .hcount_out(hcount_out),
    .vcount_out(vcount_out),
    .is_alive_out(is_alive_out)
  );

  always #5 clk_in = ~clk_in;

  // BRAM: address register then output register (2-cycle latency).
  logic [15:0] mem [8192];
  logic [12:0] bram_addr_q = '0;
  logic [15:0] bram_dout_q = '0;
  always @(posedge clk_in) begin
    if (bus.rd_en_out) bram_addr_q <= bus.rd_addr_out;
    bram_dout_q <= mem[bram_addr_q];
  end
  assign bus.rd_data_in = bram_dout_q;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the outputs must be, straight from the board rules.
  logic [10:0] m_h [4] = '{default: '0};
  logic [9:0]  m_v [4] = '{default: '0};
  logic        m_a [4] = '{default: 1'b0};
  logic        m_rd_en = 1'b0;
  logic [12:0] m_rd_addr = '0;
  logic        m_valid = 1'b0;
  logic [12:0] m_last = '0;
  logic        m_gen = 1'b0;

  always @(posedge clk_in or posedge rst_in) begin
    int col, row, addr_i;
    logic g, inb, alive, want;
    logic [12:0] a;
    logic [15:0] w;
    if (rst_in) begin
      for (int i = 0; i < 4; i++) begin
        m_h[i] <= '0; m_v[i] <= '0; m_a[i] <= 1'b0;
      end
      m_rd_en <= 1'b0; m_rd_addr <= '0; m_valid <= 1'b0; m_last <= '0; m_gen <= 1'b0;
    end else begin
      col = int'(hcount_in) / 4;
      row = int'(vcount_in) / 4;
      inb = (col < 256) && (row < 192);
      g = (hcount_in == 0 && vcount_in == 0) ? gen_sel_in : m_gen;
      addr_i = int'(g) * 4096 + row * 16 + col / 16;
      a = addr_i[12:0];
      w = mem[a];
      alive = inb && w[col % 16];
      want = inb && (!m_valid || a != m_last);
      m_gen <= g;
      m_rd_en <= want;
      if (want) begin
        m_rd_addr <= a; m_last <= a; m_valid <= 1'b1;
      end
      m_h[0] <= hcount_in; m_v[0] <= vcount_in; m_a[0] <= alive;
      for (int i = 1; i < 4; i++) begin
        m_h[i] <= m_h[i-1]; m_v[i] <= m_v[i-1]; m_a[i] <= m_a[i-1];
      end
    end
  end

  // Per-cycle compare plus logs for the literal checks.
  logic [12:0] rd_log[$];
  int          alive_log[$];
  always @(negedge clk_in) begin
    check("hcount_out", int'(hcount_out), int'(m_h[3]));
    check("vcount_out", int'(vcount_out), int'(m_v[3]));
    check("is_alive_out", int'(is_alive_out), int'(m_a[3]));
    check("rd_en_out", int'(bus.rd_en_out), int'(m_rd_en));
    check("rd_addr_out", int'(bus.rd_addr_out), int'(m_rd_addr));
    if (bus.rd_en_out) rd_log.push_back(bus.rd_addr_out);
    if (is_alive_out) alive_log.push_back(int'(hcount_out));
  end

  task automatic pix(input int h, input int v, input int g);
    @(posedge clk_in);
    #1;
    hcount_in  = 11'(h);
    vcount_in  = 10'(v);
    gen_sel_in = g[0];
  endtask

  task automatic flush();
    for (int i = 0; i < 6; i++) pix(1100, 0, 0);
  endtask

  task automatic clear_logs();
    rd_log.delete();
    alive_log.delete();
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem[13'h0000] = 16'h0001;
    mem[13'h0010] = 16'h0003;
    mem[13'h0022] = 16'h00F0;
    mem[13'h1000] = 16'h8000;
    for (int i = 0; i < 16; i++) mem[13'h0050 + i] = 16'h5555;

    // Reset
    #1 rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #2;
    check("reset hcount_out", int'(hcount_out), 0);
    check("reset is_alive_out", int'(is_alive_out), 0);
    check("reset rd_addr_out", int'(bus.rd_addr_out), 0);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    flush();

    // Line 0, gen 0: one read per word, only cell 0 alive
    clear_logs();
    for (int h = 0; h < 1344; h++) pix(h, 0, 0);
    flush();
    check("line0 read count", rd_log.size(), 16);
    bad = 0;
    for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] != 13'(i)) bad++;
    check("line0 read addrs", bad, 0);
    check("line0 alive count", alive_log.size(), 4);
    bad = 0;
    foreach (alive_log[i]) if (alive_log[i] > 3) bad++;
    check("line0 alive range", bad, 0);

    // Latency pin: pixel (700,50) appears exactly 4 cycles later
    pix(700, 50, 0);
    pix(1100, 0, 0); pix(1100, 0, 0); pix(1100, 0, 0);
    @(posedge clk_in);
    @(negedge clk_in);
    check("latency hcount", int'(hcount_out), 700);
    check("latency vcount", int'(vcount_out), 50);
    flush();

    // Blanking region: no reads, never alive
    clear_logs();
    for (int v = 768; v <= 805; v++)
      for (int h = 1024; h < 1344; h++) pix(h, v, 1);
    flush();
    check("blank reads", rd_log.size(), 0);
    check("blank alive", alive_log.size(), 0);

    // gen_sel changes mid-frame: ignored until (0,0)
    clear_logs();
    for (int h = 500; h < 1344; h++) pix(h, 10, 1);
    flush();
    check("midframe read count", rd_log.size(), 9);
    bad = 0;
    foreach (rd_log[i]) if (rd_log[i][12]) bad++;
    check("midframe gen msb", bad, 0);
    clear_logs();
    pix(0, 0, 1);
    for (int h = 1; h < 64; h++) pix(h, 0, 0);
    flush();
    check("gen1 read count", rd_log.size(), 1);
    check("gen1 first addr", (rd_log.size() > 0) ? int'(rd_log[0]) : -1, 'h1000);
    check("gen1 alive count", alive_log.size(), 4);
    check("gen1 alive first", (alive_log.size() > 0) ? alive_log[0] : -1, 60);

    // Back to gen 0, checkerboard row 5
    pix(0, 0, 0);
    flush();
    clear_logs();
    for (int h = 0; h < 1344; h++) pix(h, 20, 0);
    flush();
    check("checker read count", rd_log.size(), 16);
    check("checker first addr", (rd_log.size() > 0) ? int'(rd_log[0]) : -1, 'h50);
    check("checker alive count", alive_log.size(), 512);
    bad = 0;
    foreach (alive_log[i]) if ((alive_log[i] % 8) > 3) bad++;
    check("checker phase", bad, 0);

    // Mid-line reset: outputs clear at once, refetch at release
    for (int h = 0; h < 130; h++) pix(h, 8, 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    hcount_in = 11'd130;
    #1;
    check("rst hcount_out", int'(hcount_out), 0);
    check("rst vcount_out", int'(vcount_out), 0);
    check("rst is_alive_out", int'(is_alive_out), 0);
    check("rst rd_en_out", int'(bus.rd_en_out), 0);
    clear_logs();
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    hcount_in = 11'd140;
    for (int h = 141; h < 1344; h++) pix(h, 8, 0);
    flush();
    check("rst refetch addr", (rd_log.size() > 0) ? int'(rd_log[0]) : -1, 'h22);
    check("rst alive count", alive_log.size(), 16);
    check("rst alive first", (alive_log.size() > 0) ? alive_log[0] : -1, 144);

    // Row step at identical hcount
    clear_logs();
    pix(0, 3, 0);
    pix(0, 4, 0);
    flush();
    check("rowstep read count", rd_log.size(), 2);
    check("rowstep addr0", (rd_log.size() > 0) ? int'(rd_log[0]) : -1, 0);
    check("rowstep addr1", (rd_log.size() > 1) ? int'(rd_log[1]) : -1, 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cell_fetch.md
# cell_fetch

Display-side board reader that sits directly upstream of `cell_render`. For every pixel coordinate from the VGA timing generator it fetches the board word from the cell BRAM and extracts the liveness bit for that pixel's cell. It emits the pixel's hcount/vcount and `is_alive`, aligned with a fixed 4-cycle latency. It reads only the generation buffer selected at frame start and issues a BRAM read only when the pixel moves into a new 16-cell word.

## Interface
- `LOG_CELL_SIZE`, default 2: cell edge is 2^LOG_CELL_SIZE pixels (4×4 px cells).
- `BOARD_W`, default 256: board width in cells; a multiple of WORD_W.
- `BOARD_H`, default 192: board height in cells.
- `WORD_W`, default 16: cells per BRAM word; a power of two.
- `ADDR_W`, default 13: BRAM address width, equal to 1 + clog2(BOARD_H) + clog2(BOARD_W/WORD_W).
- `clk_in`  in  1: pixel clock; one clock, everything in this block is clocked on its rising edge.
- `rst_in`  in  1: reset, asynchronous and active-high.
- `hcount_in`  in  11: current pixel x.
- `vcount_in`  in  10: current pixel y.
- `gen_sel_in`  in  1: buffer that holds the displayable generation.
- `rd_en_out`  out  1: BRAM read strobe.
- `rd_addr_out`  out  ADDR_W: BRAM read address, formed as {gen, row, wordcol}.
- `rd_data_in`  in  WORD_W: BRAM read data.
- `hcount_out`  out  11: hcount_in delayed 4 cycles.
- `vcount_out`  out  10: vcount_in delayed 4 cycles.
- `is_alive_out`  out  1: liveness of the cell under (hcount_out, vcount_out).

## Operation
- Cell coordinates: col = hcount_in >> LOG_CELL_SIZE; row = vcount_in >> LOG_CELL_SIZE.
- Word coordinates: wordcol = col / WORD_W; bit = col % WORD_W.
- Bit i of a word is cell column wordcol*WORD_W + i, so the LSB is the leftmost cell.
- In-board test: in_board = (col < BOARD_W) && (row < BOARD_H).
  - Out-of-board pixels, which include blanking, never issue a read.
  - Out-of-board pixels produce is_alive_out = 0.
- Buffer latch:
  - `gen_q` captures gen_sel_in only on a cycle where hcount_in == 0 and vcount_in == 0.
  - gen_sel_in is ignored on every other cycle.
  - Reset value of gen_q is 0.
- Word cache:
  - The tag register holds {gen_q, row, wordcol} plus a valid bit.
  - A read is issued when in_board && (!tag_valid || tag != current tag).
  - On a read: rd_en_out = 1, rd_addr_out = current tag, tag is updated, tag_valid = 1.
  - Otherwise rd_en_out = 0 and rd_addr_out holds its previous value.
- Word register:
  - `word_q` loads rd_data_in on the cycle the 2-stage-delayed rd_en is 1.
  - Otherwise word_q holds.
  - All pixels of a word, including the fetching pixel, select from word_q, or from rd_data_in when it arrives that same cycle.
- Pipeline:
  - Shift registers carry hcount, vcount, in_board and bit through 4 stages.
  - Output stage: is_alive_out = in_board_d & word[bit_d].
- Reset:
  - Asynchronously clears tag_valid, gen_q, word_q, all delay stages and all outputs to 0.
  - The first in-board pixel after reset always fetches.
  - A reset mid-line discards any in-flight read.

## Timing
- Inputs sampled at the end of cycle t; rd_en_out/rd_addr_out valid during cycle t+1.
- BRAM has 2-cycle latency (address register, then output register), so rd_data_in is valid during cycle t+3.
- hcount_out, vcount_out and is_alive_out are registered and valid during cycle t+4. Latency is exactly 4 for every pixel, in-board or not.
- Reads are single-cycle strobes; back-to-back strobes are legal.
- With default parameters there is at most one read per 64 pixels per line.
- A tag change caused only by gen_q (at frame start) forces a fresh fetch.
- Reset values: rd_en_out=0, rd_addr_out=0, hcount_out=0, vcount_out=0, is_alive_out=0.

## Test plan
- Reset, then sweep line vcount=0, hcount 0..1343 with gen_sel_in=0 and a BRAM model whose word at addr 0 is 16'h0001:
  - Exactly 16 rd_en_out pulses, at addr 0..15.
  - is_alive_out=1 only while hcount_out is 0..3.
  - hcount_out lags hcount_in by 4.
- Sweep hcount 1024..1343 and vcount 768..805: rd_en_out stays 0 and is_alive_out stays 0.
- Set gen_sel_in=1 mid-frame at (hcount=500, vcount=10):
  - Reads keep MSB=0 until the next (0,0).
  - First read after (0,0) is addr 13'h1000.
- Checkerboard data 16'h5555 at row 5 (vcount 20..23):
  - is_alive_out toggles every 4 pixels.
  - is_alive_out=1 for hcount_out%8 in 0..3.
- Assert rst_in for 1 cycle at hcount=130, vcount=8:
  - Outputs go 0 immediately.
  - On release at hcount=140, a fetch issues for wordcol 2 (addr 13'h0022) even though it matches the old tag.
- Step vcount 3→4 at identical hcount=0: the row change forces a fetch at addr 0 then addr 16.
